// File: rtl/dff_mem_seq.sv
// Command-driven flip-flop word memory with pointer, auto-increment and FILL walk.
// READ data is registered (1 cycle) and held until rsp_ready; commands stall while a response is blocked or FILL runs.
module dff_mem_seq #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SET_ADDR = 3'd1;
  localparam logic [2:0] OP_WRITE    = 3'd2;
  localparam logic [2:0] OP_READ     = 3'd3;
  localparam logic [2:0] OP_FILL     = 3'd4;
  localparam logic [2:0] OP_SET_MODE = 3'd5;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_next;
  logic [ADDR_W-1:0]   fill_idx;
  logic [DATA_W-1:0]   fill_val;
  logic                inc;
  logic                rst_done;
  logic                accept;
  logic                addr_ok;

  // rst_done keeps cmd_ready low through reset and on the release edge itself
  assign cmd_ready = rst_done && (state == S_IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign addr_out  = ptr;
  assign ptr_next  = (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
  assign addr_ok   = 33'(cmd_data) < 33'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state     <= S_IDLE;
      ptr       <= '0;
      fill_idx  <= '0;
      fill_val  <= '0;
      inc       <= AUTO_INC;
      rst_done  <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rst_done <= 1'b1;

      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      if (state == S_FILL) begin
        mem[fill_idx] <= fill_val;
        if (fill_idx == LAST) begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          fill_idx <= '0;
        end else begin
          fill_idx <= fill_idx + ADDR_W'(1);
        end
      end

      if (accept) begin
        case (cmd_op)
          OP_NOP: ;
          OP_SET_ADDR: begin
            if (addr_ok) ptr <= ADDR_W'(cmd_data);
            else         err <= 1'b1;
          end
          OP_WRITE: begin
            mem[ptr] <= cmd_data;
            if (inc) ptr <= ptr_next;
          end
          OP_READ: begin
            rsp_data  <= mem[ptr];
            rsp_valid <= 1'b1;
            if (inc) ptr <= ptr_next;
          end
          OP_FILL: begin
            fill_val <= cmd_data;
            fill_idx <= '0;
            state    <= S_FILL;
            busy     <= 1'b1;
          end
          OP_SET_MODE: inc <= cmd_data[0];
          default: err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dff_mem_seq.sv
// Directed bench for dff_mem_seq: DEPTH=8 instance for the main sequence, DEPTH=5 instance for wrap/reset.
module tb_dff_mem_seq;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_ready;

  logic        rdy8, rv8, busy8, err8;
  logic [15:0] rd8;
  logic [2:0]  ad8;
  logic        rdy5, rv5, busy5, err5;
  logic [15:0] rd5;
  logic [2:0]  ad5;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'd0, SET_ADDR = 3'd1, WRITE = 3'd2, READ = 3'd3,
                         FILL = 3'd4, SET_MODE = 3'd5;

  dff_mem_seq #(.DATA_W(16), .DEPTH(8), .AUTO_INC(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy8),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rv8), .rsp_ready(rsp_ready),
    .rsp_data(rd8), .addr_out(ad8), .busy(busy8), .err(err8));

  dff_mem_seq #(.DATA_W(16), .DEPTH(5), .AUTO_INC(1'b1)) u5 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy5),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rv5), .rsp_ready(rsp_ready),
    .rsp_data(rd5), .addr_out(ad5), .busy(busy5), .err(err5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one clock edge; returns at edge+1.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int  cnt;
  logic rdy_seen;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0; rsp_ready = 1'b1;
    #2;
    chk("reset cmd_ready", rdy8, 0);
    chk("reset rsp_valid", rv8, 0);
    chk("reset rsp_data", rd8, 0);
    chk("reset addr", ad8, 0);
    chk("reset busy", busy8, 0);
    chk("reset err", err8, 0);

    // A WRITE held across the release edge must not be accepted
    repeat (2) @(posedge clk);
    #4;
    cmd_valid = 1'b1; cmd_op = WRITE; cmd_data = 16'h1234;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    chk("release edge no accept addr", ad8, 0);
    chk("ready after release", rdy8, 1);

    // Auto-increment write then back-to-back reads
    do_cmd(SET_ADDR, 16'd6);      chk("set_addr 6", ad8, 6);
    do_cmd(WRITE, 16'hAAAA);      chk("write addr 7", ad8, 7);
    do_cmd(WRITE, 16'hBBBB);      chk("write wrap addr 0", ad8, 0);
    do_cmd(WRITE, 16'hCCCC);      chk("write addr 1", ad8, 1);
    do_cmd(SET_ADDR, 16'd6);
    do_cmd(READ, 0); chk("rd0 data", rd8, 16'hAAAA); chk("rd0 vld", rv8, 1); chk("rd0 addr", ad8, 7);
    chk("rd0 ready", rdy8, 1);
    do_cmd(READ, 0); chk("rd1 data", rd8, 16'hBBBB); chk("rd1 vld", rv8, 1); chk("rd1 addr", ad8, 0);
    do_cmd(READ, 0); chk("rd2 data", rd8, 16'hCCCC); chk("rd2 vld", rv8, 1); chk("rd2 addr", ad8, 1);
    @(posedge clk); #1;
    chk("rsp drained", rv8, 0);

    // Backpressured response holds
    do_cmd(SET_ADDR, 16'd7);
    rsp_ready = 1'b0;
    do_cmd(READ, 0);
    for (int i = 0; i < 4; i++) begin
      chk("hold vld", rv8, 1);
      chk("hold data", rd8, 16'hBBBB);
      chk("hold ready low", rdy8, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("ready with rsp_ready", rdy8, 1);
    @(posedge clk); #1;
    chk("transfer done", rv8, 0);
    chk("ready after transfer", rdy8, 1);
    chk("ptr after held read", ad8, 0);

    // FILL walk
    do_cmd(FILL, 16'h5A5A);
    cnt = 0; rdy_seen = 1'b0;
    while (busy8 && cnt < 20) begin
      if (rdy8) rdy_seen = 1'b1;
      cnt++;
      @(posedge clk); #1;
    end
    chk("fill busy cycles", cnt, 8);
    chk("fill ready seen", rdy_seen, 0);
    chk("fill ptr unchanged", ad8, 0);
    for (int i = 0; i < 8; i++) begin
      do_cmd(READ, 0);
      chk("fill readback", rd8, 16'h5A5A);
    end
    chk("ptr after 8 reads", ad8, 0);

    // Error paths
    chk("err clear", err8, 0);
    do_cmd(SET_ADDR, 16'd9);
    chk("bad addr err", err8, 1);
    chk("bad addr ptr", ad8, 0);
    do_cmd(3'd7, 16'h1234);
    chk("illegal err", err8, 1);
    chk("illegal ptr", ad8, 0);
    do_cmd(READ, 0);
    chk("illegal no write", rd8, 16'h5A5A);

    // Auto-increment off; read right after write
    do_cmd(SET_MODE, 16'd0);
    do_cmd(SET_ADDR, 16'd3);
    do_cmd(WRITE, 16'h3333);       chk("noinc write addr", ad8, 3);
    do_cmd(READ, 0);  chk("raw read", rd8, 16'h3333); chk("noinc addr a", ad8, 3);
    do_cmd(READ, 0);  chk("noinc read 2", rd8, 16'h3333); chk("noinc addr b", ad8, 3);
    do_cmd(SET_MODE, 16'd1);

    // Reset in the 3rd FILL cycle (DEPTH=8)
    do_cmd(FILL, 16'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fill running", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("async busy clr", busy8, 0);
    chk("async err clr", err8, 0);
    chk("async rv clr", rv8, 0);
    release_reset();
    chk("post reset ready", rdy8, 1);
    for (int i = 0; i < 8; i++) begin
      do_cmd(READ, 0);
      chk("zero after reset d8", rd8, 0);
    end
    chk("busy after reset", busy8, 0);
    chk("err after reset", err8, 0);

    // Same on DEPTH=5, plus pointer wrap 4 -> 0
    do_cmd(FILL, 16'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("d5 fill running", busy5, 1);
    rst_n = 1'b0;
    #1;
    chk("d5 async busy clr", busy5, 0);
    release_reset();
    chk("d5 ready", rdy5, 1);
    for (int i = 0; i < 5; i++) begin
      do_cmd(READ, 0);
      chk("zero after reset d5", rd5, 0);
    end
    chk("d5 read wrap addr", ad5, 0);
    chk("d5 err", err5, 0);
    do_cmd(SET_ADDR, 16'd4);
    do_cmd(WRITE, 16'h4444);
    chk("d5 write wrap addr", ad5, 0);
    do_cmd(SET_ADDR, 16'd4);
    do_cmd(READ, 0);
    chk("d5 word4", rd5, 16'h4444);
    chk("d5 read wrap again", ad5, 0);
    do_cmd(SET_ADDR, 16'd5);
    chk("d5 addr 5 err", err5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_mem_seq.md
DFF_MEM_SEQ -- requirements
Module: dff_mem_seq

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits, range 1..32.
REQ-002 Parameter DEPTH, default 8: number of words, range 2..64, not required to be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 Parameter AUTO_INC, default 1: reset value of the auto-increment mode bit.
REQ-005 Port clk, in, 1: clock; all state changes on its rising edge.
REQ-006 Port rst_n, in, 1: reset; asynchronous, active-low.
REQ-007 Port cmd_valid, in, 1: command present.
REQ-008 Port cmd_ready, out, 1: command accepted this cycle when cmd_valid is also high.
REQ-009 Port cmd_op, in, 3: opcode. 0 NOP, 1 SET_ADDR, 2 WRITE, 3 READ, 4 FILL, 5 SET_MODE; 6 and 7 are illegal.
REQ-010 Port cmd_data, in, DATA_W: command operand.
REQ-011 Port rsp_valid, out, 1: read data valid.
REQ-012 Port rsp_ready, in, 1: consumer takes the data when both rsp_valid and rsp_ready are high.
REQ-013 Port rsp_data, out, DATA_W: read data.
REQ-014 Port addr_out, out, ADDR_W: current address pointer.
REQ-015 Port busy, out, 1: high while the FILL walk runs.
REQ-016 Port err, out, 1: sticky error flag.

Function
REQ-017 Storage: DEPTH x DATA_W flip-flop array with no SRAM macro, plus address pointer ptr, mode bit inc, state register {IDLE, FILL}.
REQ-018 cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready); the command is accepted on the edge where cmd_valid && cmd_ready.
REQ-019 NOP: no effect.
REQ-020 SET_ADDR: if cmd_data < DEPTH, ptr <= cmd_data[ADDR_W-1:0]. Otherwise ptr is unchanged and err <= 1.
REQ-021 WRITE: mem[ptr] <= cmd_data. If inc==1, ptr advances.
REQ-022 READ: rsp_data <= mem[ptr] and rsp_valid <= 1 on the accepting edge, so latency is 1 cycle. If inc==1, ptr advances.
REQ-023 Pointer advance: ptr == DEPTH-1 wraps to 0; otherwise ptr+1.
REQ-024 Response hold: rsp_valid and rsp_data stay stable until a cycle with rsp_valid && rsp_ready.
- On that edge rsp_valid <= 0, unless a READ is accepted on the same edge, in which case the new data loads and rsp_valid stays 1.
- Sustained throughput with rsp_ready held high is 1 read per cycle.
REQ-025 A READ accepted on the cycle after a WRITE to the same address returns the newly written data.
REQ-026 FILL: on acceptance, latch cmd_data as the fill value, state <= FILL, busy <= 1, and set an internal walk index to 0.
REQ-027 FILL state: each cycle mem[index] <= fill value and the index increments.
- After the write of index DEPTH-1, state <= IDLE and busy <= 0.
- Duration is exactly DEPTH cycles after acceptance. cmd_ready is 0 throughout.
REQ-028 FILL leaves ptr unchanged and does not affect a pending rsp_valid; the response handshake continues during FILL.
REQ-029 SET_MODE: inc <= cmd_data[0].
REQ-030 An illegal opcode sets err <= 1 and has no other effect.
REQ-031 err is cleared only by reset.
REQ-032 addr_out = ptr, combinational from the register.

Reset
REQ-033 While rst_n is low, asynchronously, the following hold:
- all memory words = 0; ptr = 0; inc = AUTO_INC; state = IDLE;
- busy = 0, rsp_valid = 0, rsp_data = 0, err = 0.
REQ-034 cmd_ready is 0 while rst_n is low and becomes 1 in the first cycle after release.
REQ-035 Reset asserted mid-FILL or while a response is pending aborts the operation. After release, the memory reads all zeros and the pending response is lost.
REQ-036 No command is accepted on the clock edge coincident with rst_n release.

Verification
REQ-037 Defaults (DATA_W=16, DEPTH=8, AUTO_INC=1): SET_ADDR 6, then WRITE 0xAAAA, 0xBBBB, 0xCCCC; SET_ADDR 6; READ x3 with rsp_ready=1 -> responses 0xAAAA, 0xBBBB, 0xCCCC on consecutive cycles; addr_out sequence 7, 0, 1.
REQ-038 READ with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data hold and cmd_ready=0; when rsp_ready goes to 1, one transfer occurs and cmd_ready returns to 1.
REQ-039 FILL 0x5A5A -> busy=1 and cmd_ready=0 for exactly 8 cycles; a subsequent read of all 8 words returns 0x5A5A; ptr is unchanged.
REQ-040 SET_ADDR 9 -> err=1 and ptr unchanged; opcode 7 -> err stays 1 with no memory change.
REQ-041 SET_MODE 0, SET_ADDR 3, READ x2 -> both reads return mem[3] and addr_out stays 3.
REQ-042 Assert rst_n low at the 3rd cycle of FILL 0xFFFF -> after release every word reads 0, busy=0 and err=0; repeat with DEPTH=5 to confirm wrap from 4 to 0.
